nios_system_mult_pipe: RTL

Parametrised iterative multiplier for the Nios II custom/ALU datapath. It succeeds the fixed 32x32-low-word multiply cell and adds:
- configurable operand width
- full-width product with signed/unsigned high-word modes (mul, mulxuu, mulxsu, mulxss)
- valid/ready handshakes on both sides

It reuses one SLICE_W x DATA_W partial-product path over multiple cycles and sits between the register-file operand stage and the writeback mux.

---
 rtl/nios_system_mult_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/nios_system_mult_pipe.sv
// Iterative SLICE_W x DATA_W multiplier with full-width product and signed/unsigned high-word modes.
// Optional build macro MULT_PIPE_EARLY_OUT_EN ends CALC once the remaining multiplier slices are zero.
module nios_system_mult_pipe #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result
);

  localparam int N  = DATA_W / SLICE_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = DATA_W + SLICE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [1:0]          op_q;
  logic                neg;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic [2*DATA_W-1:0] acc;
  logic [KW-1:0]       k;

  logic                accept_s;
  logic                src1_neg_s;
  logic                src2_neg_s;
  logic [31:0]         shamt_s;
  logic [SLICE_W-1:0]  slice_s;
  logic [PW-1:0]       prod_s;
  logic [2*DATA_W-1:0] pp_s;
  logic [2*DATA_W-1:0] acc_fix_s;
  logic                last_s;

  // MULXSU treats src1 as signed; MULXSS treats both as signed.
  assign accept_s   = (state == IDLE) && in_valid;
  assign src1_neg_s = op[1] & src1[DATA_W-1];
  assign src2_neg_s = op[1] & op[0] & src2[DATA_W-1];

  assign shamt_s   = 32'(k) * 32'(SLICE_W);
  assign slice_s   = SLICE_W'(mag2 >> shamt_s);
  assign prod_s    = PW'(mag1) * PW'(slice_s);
  assign pp_s      = (2*DATA_W)'(prod_s) << shamt_s;
  assign acc_fix_s = neg ? ({(2*DATA_W){1'b0}} - acc) : acc;

`ifdef MULT_PIPE_EARLY_OUT_EN
  assign last_s = (k == KW'(N-1)) ||
                  ((mag2 >> (shamt_s + 32'(SLICE_W))) == {DATA_W{1'b0}});
`else
  assign last_s = (k == KW'(N-1));
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_s) begin
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_next = FIX;
        end else begin
          state_next = CALC;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, slice accumulation, sign fix-up and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 2'b00;
      neg       <= 1'b0;
      mag1      <= {DATA_W{1'b0}};
      mag2      <= {DATA_W{1'b0}};
      acc       <= {(2*DATA_W){1'b0}};
      k         <= {KW{1'b0}};
      result    <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      in_ready <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept_s) begin
            op_q <= op;
            neg  <= src1_neg_s ^ src2_neg_s;
            // Most-negative operand maps onto 2^(DATA_W-1), which fits unsigned.
            mag1 <= src1_neg_s ? ({DATA_W{1'b0}} - src1) : src1;
            mag2 <= src2_neg_s ? ({DATA_W{1'b0}} - src2) : src2;
            acc  <= {(2*DATA_W){1'b0}};
            k    <= {KW{1'b0}};
          end
        end
        CALC: begin
          acc <= acc + pp_s;
          k   <= k + KW'(1);
        end
        FIX: begin
          acc       <= acc_fix_s;
          result    <= (op_q == 2'b00) ? acc_fix_s[DATA_W-1:0]
                                       : acc_fix_s[2*DATA_W-1:DATA_W];
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
